vmerge_sew: RTL and testbench
=============================

# vmerge_sew

Parametrised vector merge/move unit for the vALU. It selects per element between two source vectors under a mask register, at any SEW (8/16/32/64). An element counter tracks mask position across the beats of a multi-register group, so each beat uses the correct mask bits. Pipeline depth is set by a parameter, and address and valid travel alongside the data to the writeback arbiter.

## Interface
- REQ_DATA_WIDTH, 64: source beat width in bits. Power of two, ≥64.
- RESP_DATA_WIDTH, 64: result width. Must equal REQ_DATA_WIDTH.
- REQ_ADDR_WIDTH, 32: destination address width.
- SEW_WIDTH, 2: SEW encoding width.
- OPSEL_WIDTH, 3: op select width.
- MASK_WIDTH, 64: mask register width (max elements per group). Power of two, ≥ REQ_DATA_WIDTH/8.
- PIPE_DEPTH, 6: cycles from input to output. Must be ≥1.
- clk  in  1  clock. One clock domain; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_start  in  1  first beat of an instruction. Qualified by in_valid.
- in_sew  in  SEW_WIDTH  0=e8, 1=e16, 2=e32, 3=e64.
- in_opsel  in  OPSEL_WIDTH  0=MERGE, 1=MOVE; all other codes are reserved.
- in_addr  in  REQ_ADDR_WIDTH  destination address.
- in_mask  in  MASK_WIDTH  full v0 mask register. Held stable for the whole instruction.
- in_vec0  in  REQ_DATA_WIDTH  vs2 (mask=0 source).
- in_vec1  in  REQ_DATA_WIDTH  vs1/splatted scalar/imm (mask=1 source).
- out_valid  out  1  result valid.
- out_addr  out  REQ_ADDR_WIDTH  destination address.
- out_vec  out  RESP_DATA_WIDTH  merged beat.

## Operation
- Elements per beat: EPB = REQ_DATA_WIDTH >> (3+in_sew).
- Element counter `idx` has log2(MASK_WIDTH) bits and resets to 0.
- Base index for a beat:
  - base = 0 if in_start is set with in_valid;
  - otherwise base = idx.
- On each accepted beat, idx <= base + EPB.
- idx wraps modulo MASK_WIDTH with no error.
- Cycles with in_valid=0 leave idx unchanged.
- MERGE: element e of out = in_mask[(base+e) mod MASK_WIDTH] ? vec1[e] : vec0[e].
- MOVE: out = vec1 for every element; mask ignored.
- Reserved opsel: treat as MOVE.
- Gating:
  - a cycle with in_valid=0 inserts a bubble with vec=0 and addr=0;
  - out_vec and out_addr are 0 whenever out_valid=0.
- No backpressure. Every valid beat emerges exactly PIPE_DEPTH cycles later, and back-to-back beats are accepted every cycle.
- SEW may change between instructions. It must not change mid-instruction; behaviour in that case is undefined, but idx still advances by the new EPB.

## Timing
- Stage 0 registers:
  - base-selected mask slice;
  - vec0/vec1 gated by valid;
  - sew, op, addr, valid.
- Element select is combinational from the stage-0 registers and is registered into stage 1.
- Stages 2..PIPE_DEPTH-1 are pure delay.
- If PIPE_DEPTH=1, select is combinational from the inputs into the output register.
- Latency: in_valid at edge N produces out_valid high for exactly one cycle after edge N+PIPE_DEPTH.
- Reset:
  - out_valid=0, out_vec=0, out_addr=0, idx=0, all stage registers 0;
  - results are visible one cycle after rst is sampled high.
- Reset mid-operation flushes all in-flight beats; nothing issues after rst deasserts until new input arrives.
- rst together with in_valid: rst wins and the beat is dropped.
- in_start together with idx≠0 (truncated prior instruction): in_start wins and base is 0.

## Structure
- Shared package vmerge_pkg holds:
  - SEW encodings (SEW_E8..SEW_E64);
  - opsel codes (OP_MERGE, OP_MOVE);
  - function for elements per beat.
- The vALU decoder imports the same package.
- Sub-module vmerge_delay: parametrised valid/addr/data shift register, depth PIPE_DEPTH-1, synchronous reset to 0. It is instantiated once for the combined {valid, addr, vec} bundle.
- Per-SEW select: four generate-loop muxes, with the output chosen by the stage-0 sew.

## Test plan
- Reset and latency:
  - stimulus: assert rst 2 cycles, then a single MOVE beat with vec1=0x0123456789ABCDEF, addr=0x40;
  - required: out_valid exactly PIPE_DEPTH cycles later with that value and address, and 0 on all other cycles.
- e8 merge:
  - stimulus: mask=0x...00A5, vec0=0x1111111111111111, vec1=0x2222222222222222, start=1;
  - required: out=0x2211221111221122.
- e32 multi-beat, REQ_DATA_WIDTH=64:
  - stimulus: mask bits 3:0=0b1001, beats start, cont, with vec0=0, vec1=all-ones;
  - required: beat0 out=0x00000000FFFFFFFF, beat1 out=0xFFFFFFFF00000000, idx=4 afterwards.
- Gaps and restart:
  - stimulus: e16 beats with an in_valid=0 cycle between them, then a new in_start;
  - required: idx holds across the gap and restarts at 0, with bubble outputs of vec=0 and addr=0.
- Wrap:
  - stimulus: e8, MASK_WIDTH=64, 9 consecutive beats;
  - required: beat 8 uses mask bits 7:0 again.
- Reset mid-stream:
  - stimulus: rst asserted while 3 beats are in flight;
  - required: none of them emerge, and out_valid=0 until a new beat has traversed the pipe.

Source files
------------

// File: rtl/vmerge_pkg.sv
// Shared encodings for the vector merge/move unit; also imported by the vALU decoder.
package vmerge_pkg;

   localparam logic [1:0] SEW_E8  = 2'd0;
   localparam logic [1:0] SEW_E16 = 2'd1;
   localparam logic [1:0] SEW_E32 = 2'd2;
   localparam logic [1:0] SEW_E64 = 2'd3;

   localparam logic [2:0] OP_MERGE = 3'd0;
   localparam logic [2:0] OP_MOVE  = 3'd1;

   function automatic int unsigned elems_per_beat(input int unsigned data_width,
                                                  input logic [1:0]  sew);
      return data_width >> (32'd3 + 32'(sew));
   endfunction

endpackage

// File: rtl/vmerge_delay.sv
// Synchronously reset shift register carrying the {valid, addr, vec} bundle to writeback.
module vmerge_delay #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] data_o
);

   logic [Width-1:0] pipe_q [Depth];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(Depth); i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= data_i;
         for (int i = 1; i < int'(Depth); i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign data_o = pipe_q[Depth-1];

endmodule

// File: rtl/vmerge_sew.sv
// Vector merge/move: per-element select between vs2 and vs1 under v0, at any SEW, with an
// element counter that tracks mask position across the beats of a register group.
module vmerge_sew
   import vmerge_pkg::*;
#(
   parameter int unsigned REQ_DATA_WIDTH  = 64,
   parameter int unsigned RESP_DATA_WIDTH = 64,
   parameter int unsigned REQ_ADDR_WIDTH  = 32,
   parameter int unsigned SEW_WIDTH       = 2,
   parameter int unsigned OPSEL_WIDTH     = 3,
   parameter int unsigned MASK_WIDTH      = 64,
   parameter int unsigned PIPE_DEPTH      = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic                       in_start,
   input  logic [SEW_WIDTH-1:0]       in_sew,
   input  logic [OPSEL_WIDTH-1:0]     in_opsel,
   input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
   input  logic [MASK_WIDTH-1:0]      in_mask,
   input  logic [REQ_DATA_WIDTH-1:0]  in_vec0,
   input  logic [REQ_DATA_WIDTH-1:0]  in_vec1,
   output logic                       out_valid,
   output logic [REQ_ADDR_WIDTH-1:0]  out_addr,
   output logic [RESP_DATA_WIDTH-1:0] out_vec
);

   localparam int unsigned IdxWidth    = $clog2(MASK_WIDTH);
   localparam int unsigned MaxElems    = REQ_DATA_WIDTH / 8;
   localparam int unsigned DelayDepth  = (PIPE_DEPTH > 1) ? PIPE_DEPTH - 1 : 1;
   localparam int unsigned BundleWidth = 1 + REQ_ADDR_WIDTH + RESP_DATA_WIDTH;

   logic [IdxWidth-1:0] idx_q, idx_d, base;
   logic [MaxElems-1:0] mask_slice;

   // Element counter: in_start only counts when qualified by in_valid.
   always_comb begin
      base  = (in_valid && in_start) ? '0 : idx_q;
      idx_d = idx_q;
      if (in_valid) begin
         idx_d = base + IdxWidth'(elems_per_beat(REQ_DATA_WIDTH, in_sew));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   // Mask positions wrap modulo MASK_WIDTH through the truncated index width.
   always_comb begin
      mask_slice = '0;
      for (int e = 0; e < int'(MaxElems); e++) begin
         mask_slice[e] = in_mask[base + IdxWidth'(e)];
      end
   end

   logic                      s_valid;
   logic [SEW_WIDTH-1:0]      s_sew;
   logic [OPSEL_WIDTH-1:0]    s_op;
   logic [REQ_ADDR_WIDTH-1:0] s_addr;
   logic [MaxElems-1:0]       s_mask;
   logic [REQ_DATA_WIDTH-1:0] s_vec0, s_vec1;

   if (PIPE_DEPTH > 1) begin : g_stage0
      logic                      valid_q;
      logic [SEW_WIDTH-1:0]      sew_q;
      logic [OPSEL_WIDTH-1:0]    op_q;
      logic [REQ_ADDR_WIDTH-1:0] addr_q;
      logic [MaxElems-1:0]       mask_q;
      logic [REQ_DATA_WIDTH-1:0] vec0_q, vec1_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            sew_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            vec0_q  <= '0;
            vec1_q  <= '0;
         end else begin
            valid_q <= in_valid;
            sew_q   <= in_valid ? in_sew     : '0;
            op_q    <= in_valid ? in_opsel   : '0;
            addr_q  <= in_valid ? in_addr    : '0;
            mask_q  <= in_valid ? mask_slice : '0;
            vec0_q  <= in_valid ? in_vec0    : '0;
            vec1_q  <= in_valid ? in_vec1    : '0;
         end
      end

      assign s_valid = valid_q;
      assign s_sew   = sew_q;
      assign s_op    = op_q;
      assign s_addr  = addr_q;
      assign s_mask  = mask_q;
      assign s_vec0  = vec0_q;
      assign s_vec1  = vec1_q;
   end else begin : g_bypass
      // Single-stage pipe: select straight from the inputs into the output register.
      assign s_valid = in_valid;
      assign s_sew   = in_valid ? in_sew     : '0;
      assign s_op    = in_valid ? in_opsel   : '0;
      assign s_addr  = in_valid ? in_addr    : '0;
      assign s_mask  = in_valid ? mask_slice : '0;
      assign s_vec0  = in_valid ? in_vec0    : '0;
      assign s_vec1  = in_valid ? in_vec1    : '0;
   end

   logic [3:0][REQ_DATA_WIDTH-1:0] sel_sew;

   for (genvar g = 0; g < 4; g++) begin : g_sew
      localparam int unsigned Ew  = 8 << g;
      localparam int unsigned Nel = REQ_DATA_WIDTH / Ew;
      for (genvar e = 0; e < Nel; e++) begin : g_elem
         assign sel_sew[g][e*Ew +: Ew] = s_mask[e] ? s_vec1[e*Ew +: Ew] : s_vec0[e*Ew +: Ew];
      end
   end

   logic [RESP_DATA_WIDTH-1:0] res;

   // Reserved op codes fall through to the MOVE behaviour.
   always_comb begin
      res = s_vec1;
      if (s_op == OP_MERGE) begin
         unique case (s_sew)
            SEW_E8:  res = sel_sew[0];
            SEW_E16: res = sel_sew[1];
            SEW_E32: res = sel_sew[2];
            SEW_E64: res = sel_sew[3];
            default: res = s_vec1;
         endcase
      end
   end

   logic [BundleWidth-1:0] bundle_in, bundle_out;

   assign bundle_in = {s_valid, s_addr, res};

   vmerge_delay #(
      .Width(BundleWidth),
      .Depth(DelayDepth)
   ) u_delay (
      .clk   (clk),
      .rst   (rst),
      .data_i(bundle_in),
      .data_o(bundle_out)
   );

   assign {out_valid, out_addr, out_vec} = bundle_out;

endmodule

// File: tb/tb_vmerge_sew.sv
// Directed bench for vmerge_sew: per-cycle output scoreboard fed from hand-computed vectors.
module tb_vmerge_sew;

   localparam int unsigned D = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_start;
   logic [1:0]  in_sew;
   logic [2:0]  in_opsel;
   logic [31:0] in_addr;
   logic [63:0] in_mask, in_vec0, in_vec1;
   logic        out_valid;
   logic [31:0] out_addr;
   logic [63:0] out_vec;

   vmerge_sew #(
      .REQ_DATA_WIDTH (64),
      .RESP_DATA_WIDTH(64),
      .REQ_ADDR_WIDTH (32),
      .SEW_WIDTH      (2),
      .OPSEL_WIDTH    (3),
      .MASK_WIDTH     (64),
      .PIPE_DEPTH     (D)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_start (in_start),
      .in_sew   (in_sew),
      .in_opsel (in_opsel),
      .in_addr  (in_addr),
      .in_mask  (in_mask),
      .in_vec0  (in_vec0),
      .in_vec1  (in_vec1),
      .out_valid(out_valid),
      .out_addr (out_addr),
      .out_vec  (out_vec)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        exp_v [512];
   logic [31:0] exp_a [512];
   logic [63:0] exp_d [512];
   int          n_cmp = 0;
   int          n_err = 0;
   bit          checking = 1'b0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         check_eq($sformatf("out_valid@%0d", cyc), out_valid, exp_v[cyc]);
         check_eq($sformatf("out_addr@%0d", cyc), out_addr, exp_a[cyc]);
         check_eq($sformatf("out_vec@%0d", cyc), out_vec, exp_d[cyc]);
      end
   end

   task automatic beat(input bit v, input bit st, input logic [1:0] sew, input logic [2:0] op,
                       input logic [31:0] addr, input logic [63:0] v0, input logic [63:0] v1,
                       input logic [63:0] exp);
      in_valid = v;
      in_start = st;
      in_sew   = sew;
      in_opsel = op;
      in_addr  = addr;
      in_vec0  = v0;
      in_vec1  = v1;
      exp_v[cyc+D] = v;
      exp_a[cyc+D] = v ? addr : 32'h0;
      exp_d[cyc+D] = v ? exp : 64'h0;
      @(posedge clk);
      #1;
   endtask

   // Bubbles carry junk data and a stray start to prove gating and qualification.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         beat(1'b0, 1'b1, 2'd3, 3'd0, 32'hDEAD_BEEF, '1, '1, 64'h0);
      end
   endtask

   task automatic pulse_reset();
      rst      = 1'b1;
      in_valid = 1'b1;
      in_start = 1'b1;
      in_opsel = 3'd1;
      in_addr  = 32'h3FC;
      in_vec1  = 64'hBAD0_BAD0_BAD0_BAD0;
      for (int i = 1; i <= int'(D); i++) begin
         exp_v[cyc+i] = 1'b0;
         exp_a[cyc+i] = 32'h0;
         exp_d[cyc+i] = 64'h0;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         exp_v[i] = 1'b0;
         exp_a[i] = 32'h0;
         exp_d[i] = 64'h0;
      end
      rst = 1'b1;
      in_valid = 1'b0;
      in_start = 1'b0;
      in_sew = 2'd0;
      in_opsel = 3'd0;
      in_addr = 32'h0;
      in_mask = 64'h0;
      in_vec0 = 64'h0;
      in_vec1 = 64'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checking = 1'b1;
      check_eq("idx_after_reset", dut.idx_q, 0);

      // Reset and latency: single MOVE beat
      beat(1'b1, 1'b1, 2'd3, 3'd1, 32'h40, 64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF,
           64'h0123_4567_89AB_CDEF);
      idle(D + 2);

      // e8 merge, then reserved opsel behaving as MOVE
      in_mask = 64'hFFFF_0000_0000_00A5;
      beat(1'b1, 1'b1, 2'd0, 3'd0, 32'h80, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
           64'h2211_2211_1122_1122);
      beat(1'b1, 1'b1, 2'd0, 3'd6, 32'h88, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
           64'h2222_2222_2222_2222);

      // e32 two-beat group
      in_mask = 64'hFFFF_FFFF_FFFF_FFF9;
      beat(1'b1, 1'b1, 2'd2, 3'd0, 32'hC0, 64'h0, '1, 64'h0000_0000_FFFF_FFFF);
      beat(1'b1, 1'b0, 2'd2, 3'd0, 32'hC8, 64'h0, '1, 64'hFFFF_FFFF_0000_0000);
      check_eq("idx_e32", dut.idx_q, 4);

      // e16 with a gap, then restart from a nonzero idx
      in_mask = 64'h96;
      beat(1'b1, 1'b1, 2'd1, 3'd0, 32'h100, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
           64'hAAAA_5555_5555_AAAA);
      idle(1);
      check_eq("idx_gap_hold", dut.idx_q, 4);
      beat(1'b1, 1'b0, 2'd1, 3'd0, 32'h108, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
           64'h5555_AAAA_AAAA_5555);
      check_eq("idx_gap_cont", dut.idx_q, 8);
      beat(1'b1, 1'b1, 2'd1, 3'd0, 32'h110, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
           64'hAAAA_5555_5555_AAAA);
      check_eq("idx_restart", dut.idx_q, 4);

      // e8 wrap: nine beats over a 64-bit mask, beat 8 reuses mask bits 7:0
      in_mask = 64'h8000_0000_0000_00A5;
      for (int k = 0; k < 9; k++) begin
         logic [63:0] e;
         e = 64'h0;
         if (k == 0 || k == 8) e = 64'hFF00_FF00_00FF_00FF;
         if (k == 7) e = 64'hFF00_0000_0000_0000;
         beat(1'b1, k == 0, 2'd0, 3'd0, 32'h200 + 32'(8 * k), 64'h0, '1, e);
      end
      check_eq("idx_wrap", dut.idx_q, 8);

      // Reset with three beats in flight; reset-cycle beat is dropped too
      for (int k = 0; k < 3; k++) begin
         beat(1'b1, k == 0, 2'd3, 3'd1, 32'h300 + 32'(8 * k), 64'h0, 64'h7777_0000_0000_0000 +
              64'(k), 64'h7777_0000_0000_0000 + 64'(k));
      end
      pulse_reset();
      check_eq("idx_mid_reset", dut.idx_q, 0);
      idle(D + 2);
      beat(1'b1, 1'b1, 2'd3, 3'd1, 32'h340, 64'h0, 64'hFEED_FACE_0BAD_CAFE,
           64'hFEED_FACE_0BAD_CAFE);
      idle(D + 3);

      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
